// File: rtl/pipeline_controller_pkg.sv
// Shared controller definitions: state encodings, the per-cycle stage-control
// bundle and canned control patterns used by the pipeline controller.
package pipeline_controller_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_RUN         = 3'd1;
    localparam logic [2:0] ST_LOAD_STALL  = 3'd2;
    localparam logic [2:0] ST_MULDIV_WAIT = 3'd3;
    localparam logic [2:0] ST_FLUSH_ST    = 3'd4;

    // Enum view of the state encoding, for the EX stage / debug tooling.
    typedef enum logic [2:0] {
        IDLE        = ST_IDLE,
        RUN         = ST_RUN,
        LOAD_STALL  = ST_LOAD_STALL,
        MULDIV_WAIT = ST_MULDIV_WAIT,
        FLUSH_ST    = ST_FLUSH_ST
    } ctrl_state_t;

    typedef struct packed {
        logic fetch_en;
        logic dec_en;
        logic exec_en;
        logic bubble;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_HOLD = '{fetch_en: 1'b0, dec_en: 1'b0, exec_en: 1'b0,
                                          bubble: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t CTRL_BUBBLE = '{fetch_en: 1'b0, dec_en: 1'b0, exec_en: 1'b1,
                                            bubble: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t CTRL_FLUSH = '{fetch_en: 1'b1, dec_en: 1'b0, exec_en: 1'b1,
                                           bubble: 1'b1, flush: 1'b1};

    function automatic stage_ctrl_t run_ctrl(input logic fetch_valid);
        stage_ctrl_t c;
        c = '{fetch_en: 1'b1, dec_en: fetch_valid, exec_en: 1'b1, bubble: 1'b0, flush: 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/pipeline_controller_load_use_detect.sv
// Combinational load-use hazard compare between the decoded sources and the
// destination of a load sitting in EX. Writes to x0 never create a hazard.
module pipeline_controller_load_use_detect
    import pipeline_controller_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rd_nonzero;
    logic rs1_match;
    logic rs2_match;

    assign rd_nonzero = (ex_rd != '0);
    assign rs1_match  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard     = ex_is_load && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_controller.sv
// Fetch/decode/execute sequencer: load-use bubbles, multi-cycle M-extension
// holds, post-branch flushes, deferred halt and saturating perf counters.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int CNT_W             = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  START,
    input  logic                  HALT,
    input  logic                  FETCH_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic                  EX_IS_LOAD,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic                  EX_IS_MULDIV,
    input  logic                  MULDIV_DONE,
    input  logic                  BRANCH_TAKEN,
    output logic                  FETCH_ENABLED,
    output logic                  DECODER_ENABLED,
    output logic                  EXEC_ENABLED,
    output logic                  BUBBLE,
    output logic                  FLUSH,
    output logic [2:0]            STATE,
    output logic [CNT_W-1:0]      STALL_CNT,
    output logic [CNT_W-1:0]      FLUSH_CNT
);

    localparam int DC_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int DC_W   = $clog2(DC_MAX + 1);

    logic [2:0]       state_q;
    logic [2:0]       next_state;
    logic [DC_W-1:0]  dcnt_q;
    logic [DC_W-1:0]  next_dcnt;
    logic             halt_pending_q;
    logic             next_halt_pending;
    logic             set_pending;
    logic             halt_req;
    logic             hazard;
    logic             stall_cycle;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    stage_ctrl_t      ctrl;

    pipeline_controller_load_use_detect u_load_use_detect (
        .id_rs1      (ID_RS1),
        .id_rs2      (ID_RS2),
        .id_uses_rs1 (ID_USES_RS1),
        .id_uses_rs2 (ID_USES_RS2),
        .ex_is_load  (EX_IS_LOAD),
        .ex_rd       (EX_RD),
        .hazard      (hazard)
    );

    assign halt_req = HALT || halt_pending_q;

    // The down-counter holds the cycles still to spend in a stall/flush state,
    // so the first (detecting) cycle in RUN already counts toward the total.
    // stall_cycle marks every cycle the pipe is held for a hazard or mul/div,
    // including that detecting cycle, but not the MULDIV_DONE release cycle.
    always_comb begin
        ctrl        = CTRL_HOLD;
        next_state  = state_q;
        next_dcnt   = dcnt_q;
        set_pending = 1'b0;
        stall_cycle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (BRANCH_TAKEN) begin
                    ctrl        = CTRL_FLUSH;
                    set_pending = HALT;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = ST_FLUSH_ST;
                        next_dcnt  = DC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (EX_IS_MULDIV && !MULDIV_DONE) begin
                    ctrl        = CTRL_HOLD;
                    stall_cycle = 1'b1;
                    set_pending = HALT;
                    next_state  = ST_MULDIV_WAIT;
                end else if (hazard) begin
                    ctrl        = CTRL_BUBBLE;
                    stall_cycle = 1'b1;
                    set_pending = HALT;
                    if (LOAD_STALL_CYCLES > 1) begin
                        next_state = ST_LOAD_STALL;
                        next_dcnt  = DC_W'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (halt_req) begin
                    next_state = ST_IDLE;
                end else begin
                    ctrl = run_ctrl(FETCH_VALID);
                end
            end
            ST_LOAD_STALL: begin
                ctrl        = CTRL_BUBBLE;
                stall_cycle = 1'b1;
                set_pending = HALT;
                next_dcnt   = dcnt_q - DC_W'(1);
                if (dcnt_q == DC_W'(1)) begin
                    next_state = halt_req ? ST_IDLE : ST_RUN;
                end
            end
            ST_MULDIV_WAIT: begin
                set_pending = HALT;
                if (MULDIV_DONE) begin
                    ctrl.exec_en = 1'b1;
                    next_state   = halt_req ? ST_IDLE : ST_RUN;
                end else begin
                    stall_cycle = 1'b1;
                end
            end
            ST_FLUSH_ST: begin
                ctrl        = CTRL_FLUSH;
                set_pending = HALT;
                next_dcnt   = dcnt_q - DC_W'(1);
                if (dcnt_q == DC_W'(1)) begin
                    next_state = halt_req ? ST_IDLE : ST_RUN;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign next_halt_pending = (next_state == ST_IDLE) ? 1'b0 : (halt_pending_q || set_pending);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q        <= ST_IDLE;
            dcnt_q         <= '0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= next_state;
            dcnt_q         <= next_dcnt;
            halt_pending_q <= next_halt_pending;
        end
    end

    // Performance counters stick at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_cycle && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ctrl.flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign FETCH_ENABLED   = ctrl.fetch_en;
    assign DECODER_ENABLED = ctrl.dec_en;
    assign EXEC_ENABLED    = ctrl.exec_en;
    assign BUBBLE          = ctrl.bubble;
    assign FLUSH           = ctrl.flush;
    assign STATE           = state_q;
    assign STALL_CNT       = stall_cnt_q;
    assign FLUSH_CNT       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scenario bench for pipeline_controller: expected per-cycle outputs are queued
// as stimulus is applied and compared once the outputs settle.
module tb_pipeline_controller;
    import pipeline_controller_pkg::*;

    logic        CLK;
    logic        RSTN;
    logic        START;
    logic        HALT;
    logic        FETCH_VALID;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic        ID_USES_RS1;
    logic        ID_USES_RS2;
    logic        EX_IS_LOAD;
    logic [4:0]  EX_RD;
    logic        EX_IS_MULDIV;
    logic        MULDIV_DONE;
    logic        BRANCH_TAKEN;
    logic        FETCH_ENABLED;
    logic        DECODER_ENABLED;
    logic        EXEC_ENABLED;
    logic        BUBBLE;
    logic        FLUSH;
    logic [2:0]  STATE;
    logic [31:0] STALL_CNT;
    logic [31:0] FLUSH_CNT;

    logic [7:0]  outs;
    logic [7:0]  want;
    logic [7:0]  exp_q[$];
    int          checks;
    int          failures;
    int          exp_stall;
    int          exp_flush;

    pipeline_controller #(
        .LOAD_STALL_CYCLES (1),
        .FLUSH_CYCLES      (2),
        .CNT_W             (32)
    ) dut (
        .CLK             (CLK),
        .RSTN            (RSTN),
        .START           (START),
        .HALT            (HALT),
        .FETCH_VALID     (FETCH_VALID),
        .ID_RS1          (ID_RS1),
        .ID_RS2          (ID_RS2),
        .ID_USES_RS1     (ID_USES_RS1),
        .ID_USES_RS2     (ID_USES_RS2),
        .EX_IS_LOAD      (EX_IS_LOAD),
        .EX_RD           (EX_RD),
        .EX_IS_MULDIV    (EX_IS_MULDIV),
        .MULDIV_DONE     (MULDIV_DONE),
        .BRANCH_TAKEN    (BRANCH_TAKEN),
        .FETCH_ENABLED   (FETCH_ENABLED),
        .DECODER_ENABLED (DECODER_ENABLED),
        .EXEC_ENABLED    (EXEC_ENABLED),
        .BUBBLE          (BUBBLE),
        .FLUSH           (FLUSH),
        .STATE           (STATE),
        .STALL_CNT       (STALL_CNT),
        .FLUSH_CNT       (FLUSH_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign outs = {FETCH_ENABLED, DECODER_ENABLED, EXEC_ENABLED, BUBBLE, FLUSH, STATE};

    function automatic logic [7:0] eo(input logic fe, input logic de, input logic ee,
                                      input logic bub, input logic fl, input logic [2:0] st);
        return {fe, de, ee, bub, fl, st};
    endfunction

    task automatic clear_inputs();
        START = 0; HALT = 0; FETCH_VALID = 1;
        ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        EX_IS_LOAD = 0; EX_RD = 0; EX_IS_MULDIV = 0; MULDIV_DONE = 0; BRANCH_TAKEN = 0;
    endtask

    // Queue the expectation for the inputs just driven and let outputs settle.
    task automatic apply(input logic [7:0] e);
        exp_q.push_back(e);
        #2;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 0;
        clear_inputs();
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL reset_outs got=%b want=%b", outs, want); end
        checks++;
        if (STALL_CNT !== 32'd0) begin failures++; $display("[TB] FAIL reset_stall_cnt got=%0d want=0", STALL_CNT); end
        checks++;
        if (FLUSH_CNT !== 32'd0) begin failures++; $display("[TB] FAIL reset_flush_cnt got=%0d want=0", FLUSH_CNT); end
        next_cycle();
        RSTN = 1;
        next_cycle();
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL idle_no_start got=%b want=%b", outs, want); end
        next_cycle();
    endtask

    task automatic test_start_run();
        START = 1;
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL start_cycle got=%b want=%b", outs, want); end
        next_cycle();
        START = 0;
        for (int i = 0; i < 4; i++) begin
            FETCH_VALID = (i != 2);
            apply(eo(1, i != 2, 1, 0, 0, ST_RUN));
            want = exp_q.pop_front(); checks++;
            if (outs !== want) begin failures++; $display("[TB] FAIL run_normal[%0d] got=%b want=%b", i, outs, want); end
            next_cycle();
        end
        FETCH_VALID = 1;
    endtask

    task automatic test_load_use();
        // rs1 hazard, rs2 hazard, then a matching rs1 that is not read
        for (int i = 0; i < 3; i++) begin
            EX_IS_LOAD = 1;
            EX_RD = (i == 1) ? 5'd9 : 5'd5;
            ID_RS1 = 5'd5; ID_RS2 = (i == 1) ? 5'd9 : 5'd7;
            ID_USES_RS1 = (i != 2); ID_USES_RS2 = 1;
            if (i < 2) begin
                apply(eo(0, 0, 1, 1, 0, ST_RUN));
                exp_stall++;
            end else begin
                apply(eo(1, 1, 1, 0, 0, ST_RUN));
            end
            want = exp_q.pop_front(); checks++;
            if (outs !== want) begin failures++; $display("[TB] FAIL load_use[%0d] got=%b want=%b", i, outs, want); end
            next_cycle();
            clear_inputs();
            apply(eo(1, 1, 1, 0, 0, ST_RUN));
            want = exp_q.pop_front(); checks++;
            if (outs !== want) begin failures++; $display("[TB] FAIL load_use_after[%0d] got=%b want=%b", i, outs, want); end
            next_cycle();
        end
        checks++;
        if (STALL_CNT !== 32'(exp_stall)) begin failures++; $display("[TB] FAIL load_use_stall_cnt got=%0d want=%0d", STALL_CNT, exp_stall); end
    endtask

    task automatic test_x0();
        EX_IS_LOAD = 1; EX_RD = 0; ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 1; ID_USES_RS2 = 1;
        apply(eo(1, 1, 1, 0, 0, ST_RUN));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL x0_no_stall got=%b want=%b", outs, want); end
        next_cycle();
        clear_inputs();
        checks++;
        if (STALL_CNT !== 32'(exp_stall)) begin failures++; $display("[TB] FAIL x0_stall_cnt got=%0d want=%0d", STALL_CNT, exp_stall); end
    endtask

    task automatic test_muldiv();
        EX_IS_MULDIV = 1;
        for (int i = 0; i < 34; i++) begin
            MULDIV_DONE = (i == 33);
            if (i == 0) apply(eo(0, 0, 0, 0, 0, ST_RUN));
            else if (i < 33) apply(eo(0, 0, 0, 0, 0, ST_MULDIV_WAIT));
            else apply(eo(0, 0, 1, 0, 0, ST_MULDIV_WAIT));
            want = exp_q.pop_front(); checks++;
            if (outs !== want) begin failures++; $display("[TB] FAIL muldiv[%0d] got=%b want=%b", i, outs, want); end
            next_cycle();
        end
        exp_stall += 33;
        clear_inputs();
        apply(eo(1, 1, 1, 0, 0, ST_RUN));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL muldiv_resume got=%b want=%b", outs, want); end
        checks++;
        if (STALL_CNT !== 32'(exp_stall)) begin failures++; $display("[TB] FAIL muldiv_stall_cnt got=%0d want=%0d", STALL_CNT, exp_stall); end
        next_cycle();
        EX_IS_MULDIV = 1; MULDIV_DONE = 1;
        apply(eo(1, 1, 1, 0, 0, ST_RUN));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL muldiv_same_cycle got=%b want=%b", outs, want); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_hazard(input logic halt_in_flush);
        BRANCH_TAKEN = 1; EX_IS_LOAD = 1; EX_RD = 5'd3; ID_RS1 = 5'd3; ID_USES_RS1 = 1;
        apply(eo(1, 0, 1, 1, 1, ST_RUN));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL branch_wins got=%b want=%b", outs, want); end
        next_cycle();
        clear_inputs();
        HALT = halt_in_flush;
        apply(eo(1, 0, 1, 1, 1, ST_FLUSH_ST));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL flush_st got=%b want=%b", outs, want); end
        next_cycle();
        HALT = 0;
        exp_flush += 2;
        if (halt_in_flush) apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        else apply(eo(1, 1, 1, 0, 0, ST_RUN));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL after_flush got=%b want=%b", outs, want); end
        checks++;
        if (FLUSH_CNT !== 32'(exp_flush)) begin failures++; $display("[TB] FAIL flush_cnt got=%0d want=%0d", FLUSH_CNT, exp_flush); end
        checks++;
        if (STALL_CNT !== 32'(exp_stall)) begin failures++; $display("[TB] FAIL branch_stall_cnt got=%0d want=%0d", STALL_CNT, exp_stall); end
        next_cycle();
    endtask

    task automatic test_halt();
        test_branch_hazard(1'b1);
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL halt_stays_idle got=%b want=%b", outs, want); end
        next_cycle();
        START = 1;
        next_cycle();
        START = 0; HALT = 1;
        apply(eo(0, 0, 0, 0, 0, ST_RUN));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL halt_in_run got=%b want=%b", outs, want); end
        next_cycle();
        HALT = 0;
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL halt_run_idle got=%b want=%b", outs, want); end
        next_cycle();
        // halt raised mid mul/div is remembered until the unit finishes
        START = 1;
        next_cycle();
        START = 0; EX_IS_MULDIV = 1;
        next_cycle();
        HALT = 1;
        next_cycle();
        HALT = 0; MULDIV_DONE = 1;
        apply(eo(0, 0, 1, 0, 0, ST_MULDIV_WAIT));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL pending_done got=%b want=%b", outs, want); end
        next_cycle();
        clear_inputs();
        exp_stall += 2;
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL pending_idle got=%b want=%b", outs, want); end
        checks++;
        if (STALL_CNT !== 32'(exp_stall)) begin failures++; $display("[TB] FAIL halt_stall_cnt got=%0d want=%0d", STALL_CNT, exp_stall); end
        next_cycle();
    endtask

    task automatic test_reset_mid_muldiv();
        START = 1;
        next_cycle();
        START = 0; EX_IS_MULDIV = 1;
        next_cycle();
        apply(eo(0, 0, 0, 0, 0, ST_MULDIV_WAIT));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL pre_reset_wait got=%b want=%b", outs, want); end
        RSTN = 0;
        exp_stall = 0; exp_flush = 0;
        apply(eo(0, 0, 0, 0, 0, ST_IDLE));
        want = exp_q.pop_front(); checks++;
        if (outs !== want) begin failures++; $display("[TB] FAIL async_reset_outs got=%b want=%b", outs, want); end
        checks++;
        if (STALL_CNT !== 32'(exp_stall)) begin failures++; $display("[TB] FAIL async_reset_stall got=%0d want=0", STALL_CNT); end
        checks++;
        if (FLUSH_CNT !== 32'(exp_flush)) begin failures++; $display("[TB] FAIL async_reset_flush got=%0d want=0", FLUSH_CNT); end
        next_cycle();
        clear_inputs();
        RSTN = 1;
        next_cycle();
    endtask

    initial begin
        checks = 0; failures = 0; exp_stall = 0; exp_flush = 0;
        test_reset();
        test_start_run();
        test_load_use();
        test_x0();
        test_muldiv();
        test_branch_hazard(1'b0);
        test_halt();
        test_reset_mid_muldiv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
